// File: rtl/clk_gen_pkg.sv
// Shared types for the programmable clock-pattern generator: FSM states,
// phase-length configuration record and the zero-length clamp.
package clk_gen_pkg;

    localparam int CFG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } gen_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] low;
    } phase_cfg_t;

    // A zero-length phase would stall the counter compare, so it becomes one cycle.
    function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] len);
        return (len == '0) ? CFG_W'(1) : len;
    endfunction

endpackage

// File: rtl/clk_gen_cfg_slot.sv
// One-entry valid/ready holding register for phase config; the held entry is
// copied into the active config whenever the generator signals a safe point.
module clk_gen_cfg_slot
    import clk_gen_pkg::*;
#(
    parameter int DEF_HIGH = 18,
    parameter int DEF_LOW  = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  phase_cfg_t req_cfg,
    input  logic       apply,
    output phase_cfg_t act_cfg
);

    logic       pend_vld;
    phase_cfg_t pend_cfg;

    assign cfg_ready = !pend_vld;

    // Capture and copy are mutually exclusive: capture needs the slot empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_cfg <= '0;
            act_cfg  <= '{high: CFG_W'(DEF_HIGH), low: CFG_W'(DEF_LOW)};
        end else if (cfg_valid && cfg_ready) begin
            pend_vld <= 1'b1;
            pend_cfg <= '{high: clamp_len(req_cfg.high), low: clamp_len(req_cfg.low)};
        end else if (pend_vld && apply) begin
            pend_vld <= 1'b0;
            act_cfg  <= pend_cfg;
        end
    end

endmodule

// File: rtl/clk_period_gen.sv
// Programmable clock-pattern generator: registered clk_out with independent
// high/low phase lengths; new config only lands on a period boundary or in IDLE.
module clk_period_gen
    import clk_gen_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEF_HIGH = 18,
    parameter int DEF_LOW  = 18,
    parameter int PCNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    output logic              clk_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [PCNT_W-1:0] period_cnt
);

    gen_state_t       state;
    logic [CNT_W-1:0] cnt;
    phase_cfg_t       act_cfg;
    phase_cfg_t       req_cfg;
    logic             boundary;
    logic             apply;

    assign req_cfg  = '{high: cfg_high, low: cfg_low};
    assign boundary = (state == LOW) && (cnt == act_cfg.low - CFG_W'(1));
    assign apply    = boundary || (state == IDLE);

    clk_gen_cfg_slot #(
        .DEF_HIGH (DEF_HIGH),
        .DEF_LOW  (DEF_LOW)
    ) u_cfg_slot (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .req_cfg   (req_cfg),
        .apply     (apply),
        .act_cfg   (act_cfg)
    );

    // Pulses are set in the same update as clk_out so they line up with its edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            period_cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state      <= HIGH;
                        clk_out    <= 1'b1;
                        rise_pulse <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == act_cfg.high - CFG_W'(1)) begin
                        state      <= LOW;
                        cnt        <= '0;
                        clk_out    <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (boundary) begin
                        cnt        <= '0;
                        period_cnt <= period_cnt + PCNT_W'(1);
                        if (en) begin
                            state      <= HIGH;
                            clk_out    <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_gen.sv
// Bench for clk_period_gen: period-position reference model, directed scenarios,
// randomized config/enable traffic and rise-to-rise realtime measurement.
`timescale 1ns/1ps
module tb_clk_period_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_high = '0;
    logic [15:0] cfg_low = '0;
    logic        clk_out;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [31:0] period_cnt;

    int nvec = 0;
    int nerr = 0;

    clk_period_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .clk_out    (clk_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .period_cnt (period_cnt)
    );

    always #5 clk = ~clk;

    realtime dut_last = 0.0;
    realtime dut_prev = 0.0;
    always @(posedge clk_out) begin
        dut_prev = dut_last;
        dut_last = $realtime;
    end

    // Reference model: a running generator sits at position m_pos of a period
    // of m_h + m_l cycles; clk_out is high for the first m_h positions.
    bit          m_run, m_pv, m_out, m_rise, m_fall, m_cap, m_cont, meas_vld;
    int unsigned m_pos, m_h, m_l, m_ph, m_pl, m_per;
    logic [31:0] m_pc;
    longint      meas_ps, exp_ps;

    function automatic void model_reset();
        m_run = 0; m_pv = 0; m_out = 0; m_rise = 0; m_fall = 0; m_cap = 0; m_cont = 0;
        m_pos = 0; m_h = 18; m_l = 18; m_ph = 0; m_pl = 0; m_pc = '0; meas_vld = 0;
    endfunction

    function automatic logic [35:0] obs();
        return {clk_out, rise_pulse, fall_pulse, cfg_ready, period_cnt};
    endfunction

    function automatic logic [35:0] expv();
        return {m_out, m_rise, m_fall, !m_pv, m_pc};
    endfunction

    task automatic tick();
        bit bnd, app, restart, newout;
        bnd     = m_run && (m_pos == m_h + m_l - 1);
        app     = m_pv && (!m_run || bnd);
        m_cap   = cfg_valid && !m_pv;
        m_cont  = bnd && en;
        m_per   = m_h + m_l;
        restart = !m_run || bnd;
        if (bnd) m_pc = m_pc + 1;
        if (app) begin
            m_h = m_ph; m_l = m_pl; m_pv = 0;
        end
        if (m_cap) begin
            m_pv = 1;
            m_ph = (cfg_high == 0) ? 1 : cfg_high;
            m_pl = (cfg_low == 0) ? 1 : cfg_low;
        end
        m_run  = restart ? en : 1'b1;
        m_pos  = restart ? 0 : m_pos + 1;
        newout = m_run && (m_pos < m_h);
        m_rise = newout && !m_out;
        m_fall = !newout && m_out;
        m_out  = newout;
        @(posedge clk);
        @(negedge clk);
        meas_vld = m_rise && m_cont;
        meas_ps  = longint'((dut_last - dut_prev) * 1000.0);
        exp_ps   = longint'(m_per) * 10000;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nvec++;
        if (obs() !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            nerr++;
            $display("FAIL reset got=%h exp=%h", obs(), {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        end
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default();
        en = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick();
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL default cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (meas_vld) begin
                nvec++;
                if (meas_ps !== exp_ps) begin
                    nerr++;
                    $display("FAIL default_period got=%0dps exp=%0dps", meas_ps, exp_ps);
                end
            end
            if (i == 36 || i == 72) begin
                nvec++;
                if (rise_pulse !== 1'b1 || period_cnt !== 32'(i / 36)) begin
                    nerr++;
                    $display("FAIL default_rise cyc=%0d got rise=%b cnt=%0d exp rise=1 cnt=%0d",
                             i, rise_pulse, period_cnt, i / 36);
                end
            end
        end
    endtask

    task automatic test_cfg_midhigh();
        int k = 0;
        while (!(m_run && m_h == 18 && m_pos == 4) && k < 100) begin
            tick(); k++;
        end
        if (k >= 100) begin
            nerr++;
            $display("FAIL midhigh_wait got=timeout exp=HIGH position 4");
        end
        cfg_valid = 1'b1; cfg_high = 16'd5; cfg_low = 16'd3;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (m_cap) begin
                cfg_valid = 1'b0;
                nvec++;
                if (cfg_ready !== 1'b0) begin
                    nerr++;
                    $display("FAIL midhigh_ready got=%b exp=0", cfg_ready);
                end
            end
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL midhigh cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (meas_vld) begin
                nvec++;
                if (meas_ps !== exp_ps) begin
                    nerr++;
                    $display("FAIL midhigh_period got=%0dps exp=%0dps", meas_ps, exp_ps);
                end
            end
        end
    endtask

    task automatic test_clamp();
        bit prev_seen = 0;
        bit prev_out = 0;
        cfg_valid = 1'b1; cfg_high = 16'd0; cfg_low = 16'd0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_cap) cfg_valid = 1'b0;
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL clamp cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (m_run && m_h == 1 && m_l == 1 && m_pos == 1 && prev_seen) begin
                nvec++;
                if (clk_out !== !prev_out || fall_pulse !== 1'b1) begin
                    nerr++;
                    $display("FAIL clamp_toggle cyc=%0d got out=%b fall=%b exp out=%b fall=1",
                             i, clk_out, fall_pulse, !prev_out);
                end
            end
            prev_seen = m_run && m_h == 1;
            prev_out  = clk_out;
        end
    endtask

    task automatic test_en_drop();
        int k = 0;
        logic [31:0] pc0;
        cfg_valid = 1'b1; cfg_high = 16'd4; cfg_low = 16'd4;
        while (!(m_run && m_h == 4 && m_pos == 1) && k < 100) begin
            tick(); k++;
            if (m_cap) cfg_valid = 1'b0;
        end
        if (k >= 100) begin
            nerr++;
            $display("FAIL endrop_wait got=timeout exp=4/4 HIGH position 1");
        end
        en  = 1'b0;
        pc0 = m_pc;
        for (int i = 0; i < 12; i++) begin
            tick();
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL endrop cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        nvec++;
        if (clk_out !== 1'b0 || period_cnt !== pc0 + 32'd1) begin
            nerr++;
            $display("FAIL endrop_idle got out=%b cnt=%0d exp out=0 cnt=%0d", clk_out, period_cnt, pc0 + 1);
        end
    endtask

    task automatic test_rst_low();
        int k = 0;
        en = 1'b1;
        while (!(m_run && m_h == 4 && m_pos == 5) && k < 100) begin
            tick(); k++;
        end
        if (k >= 100) begin
            nerr++;
            $display("FAIL rstlow_wait got=timeout exp=LOW position 5");
        end
        cfg_valid = 1'b1; cfg_high = 16'd9; cfg_low = 16'd7;
        tick();
        cfg_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs() !== {1'b0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
            nerr++;
            $display("FAIL rstlow_async got=%h exp=%h", obs(), {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
        end
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 80; i++) begin
            tick();
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL rstlow_resume cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (i == 36) begin
                nvec++;
                if (rise_pulse !== 1'b1 || period_cnt !== 32'd1) begin
                    nerr++;
                    $display("FAIL rstlow_default got rise=%b cnt=%0d exp rise=1 cnt=1", rise_pulse, period_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            en = ($urandom_range(0, 11) != 0);
            if (!cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_high  = 16'($urandom_range(0, 6));
                cfg_low   = 16'($urandom_range(0, 6));
            end
            tick();
            if (m_cap) cfg_valid = 1'b0;
            nvec++;
            if (obs() !== expv()) begin
                nerr++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (meas_vld) begin
                nvec++;
                if (meas_ps !== exp_ps) begin
                    nerr++;
                    $display("FAIL random_period got=%0dps exp=%0dps", meas_ps, exp_ps);
                end
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_cfg_midhigh();
        test_clamp();
        test_en_drop();
        test_rst_low();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
